writeback_arbiter: RTL and testbench

Write-side initiator for the 16×32 register file: collects results from the ALU and the load unit, queues them, and drives the file's `WriteRegister`/`WriteData`/`RegWrite` port one write per cycle. Sits between the execute/memory stages and the register file. Exports a pending-destination bitmap so the decode stage can stall on in-flight writes.

---
 rtl/writeback_pkg.sv | 23 ++
 rtl/wb_fifo.sv | 105 ++++++++++
 rtl/writeback_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_writeback_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_pkg.sv
// -----------------------------------------------------------------------------
// writeback_pkg
// Shared definitions for the register-file write-back path: default widths,
// register count, the queued write record and the source indices used by the
// round-robin arbiter.
// -----------------------------------------------------------------------------
package writeback_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 4;
    localparam int NUM_REGS       = 2 ** DEFAULT_ADDR_W;

    // One pending register-file write at the default widths.
    typedef struct packed {
        logic [DEFAULT_ADDR_W-1:0] rd;
        logic [DEFAULT_DATA_W-1:0] data;
    } wb_entry_t;

    // Source indices; also the encoding of the round-robin preference flop.
    localparam logic SRC_MEM = 1'b0;
    localparam logic SRC_ALU = 1'b1;

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Small FIFO of {rd, data} write records, one instance per write source.
// Each slot carries its own valid bit, so full/empty fall out of the valid
// vector and the per-slot valid/rd view can feed hazard and busy logic.
//
// Ports:
//   clock, reset_n           clock, async active-low reset
//   push, push_rd, push_data enqueue (ignored when full)
//   pop                      dequeue head (ignored when empty)
//   head_rd, head_data       oldest entry
//   full, empty              occupancy flags
//   entry_valid[DEPTH]       per-slot valid bits
//   entry_rd[DEPTH*ADDR_W]   per-slot destination registers, slot i at i*ADDR_W
// -----------------------------------------------------------------------------
module wb_fifo #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [ADDR_W-1:0]        push_rd,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [ADDR_W-1:0]        head_rd,
    output logic [DATA_W-1:0]        head_data,
    output logic                     full,
    output logic                     empty,
    output logic [DEPTH-1:0]         entry_valid,
    output logic [DEPTH*ADDR_W-1:0]  entry_rd
);

    localparam int              PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [ADDR_W-1:0] rd_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic do_push, do_pop;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign full    = &valid_q;
    assign empty   = ~|valid_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: every signal assigned here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        valid_d  = valid_q;
        if (do_pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = ptr_inc(rd_ptr_q);
        end
        if (do_push) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = ptr_inc(wr_ptr_q);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= valid_d;
        end
    end

    // NOTE: payload storage has no reset; a slot is only observed while its
    // valid bit is set, and the valid bits are reset.
    always_ff @(posedge clock) begin
        if (do_push) begin
            rd_mem[wr_ptr_q]   <= push_rd;
            data_mem[wr_ptr_q] <= push_data;
        end
    end

    assign head_rd     = rd_mem[rd_ptr_q];
    assign head_data   = data_mem[rd_ptr_q];
    assign entry_valid = valid_q;

    always_comb begin
        entry_rd = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_rd[i*ADDR_W +: ADDR_W] = rd_mem[i];
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// -----------------------------------------------------------------------------
// writeback_arbiter
// Collects ALU and load-unit results into per-source FIFOs and issues one
// register-file write per cycle through a registered output stage. Blocks
// cross-source WAW reordering and exports a busy bitmap for decode stalls.
//
// Ports:
//   clock, reset_n                     clock, async active-low reset
//   alu_valid/ready/rd/data            ALU result handshake
//   mem_valid/ready/rd/data            load-unit result handshake
//   RegWrite, WriteRegister, WriteData register-file write port (registered)
//   busy_mask                          bit r set while a write to r is pending
//
// Optional build macro WB_FWD_EN adds a combinational forwarding view:
//   fwd_rs1, fwd_rs2   in   source registers to look up
//   fwd_hit1, fwd_hit2 out  output port is writing that register this cycle
//   fwd_data1/2        out  WriteData on a hit, else 0
// -----------------------------------------------------------------------------
module writeback_arbiter
    import writeback_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDR_W-1:0]        alu_rd,
    input  logic [DATA_W-1:0]        alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [ADDR_W-1:0]        mem_rd,
    input  logic [DATA_W-1:0]        mem_data,
    output logic                     RegWrite,
    output logic [ADDR_W-1:0]        WriteRegister,
    output logic [DATA_W-1:0]        WriteData,
    output logic [(2**ADDR_W)-1:0]   busy_mask
`ifdef WB_FWD_EN
    ,
    input  logic [ADDR_W-1:0]        fwd_rs1,
    input  logic [ADDR_W-1:0]        fwd_rs2,
    output logic                     fwd_hit1,
    output logic                     fwd_hit2,
    output logic [DATA_W-1:0]        fwd_data1,
    output logic [DATA_W-1:0]        fwd_data2
`endif
);

    localparam int NREG = 2 ** ADDR_W;

    logic                     alu_push, alu_pop, alu_full, alu_empty;
    logic                     mem_push, mem_pop, mem_full, mem_empty;
    logic [ADDR_W-1:0]        alu_head_rd, mem_head_rd;
    logic [DATA_W-1:0]        alu_head_data, mem_head_data;
    logic [FIFO_DEPTH-1:0]    alu_entry_valid, mem_entry_valid;
    logic [FIFO_DEPTH*ADDR_W-1:0] alu_entry_rd, mem_entry_rd;

    logic                     alu_rd_in_mem, mem_rd_in_alu;
    logic                     any_pending, grant;
    logic                     pref_q, pref_d;
    logic                     reg_write_q, reg_write_d;
    logic [ADDR_W-1:0]        wreg_q, wreg_d;
    logic [DATA_W-1:0]        wdata_q, wdata_d;

    wb_fifo #(.DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_alu_fifo (
        .clock       (clock),
        .reset_n     (reset_n),
        .push        (alu_push),
        .push_rd     (alu_rd),
        .push_data   (alu_data),
        .pop         (alu_pop),
        .head_rd     (alu_head_rd),
        .head_data   (alu_head_data),
        .full        (alu_full),
        .empty       (alu_empty),
        .entry_valid (alu_entry_valid),
        .entry_rd    (alu_entry_rd)
    );

    wb_fifo #(.DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem_fifo (
        .clock       (clock),
        .reset_n     (reset_n),
        .push        (mem_push),
        .push_rd     (mem_rd),
        .push_data   (mem_data),
        .pop         (mem_pop),
        .head_rd     (mem_head_rd),
        .head_data   (mem_head_data),
        .full        (mem_full),
        .empty       (mem_empty),
        .entry_valid (mem_entry_valid),
        .entry_rd    (mem_entry_rd)
    );

    // Cross-source WAW check: an incoming rd may not overtake a queued write
    // to the same register in the other FIFO. rd 0 is never written, so it
    // never stalls.
    always_comb begin
        alu_rd_in_mem = 1'b0;
        mem_rd_in_alu = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (mem_entry_valid[i] && mem_entry_rd[i*ADDR_W +: ADDR_W] == alu_rd)
                alu_rd_in_mem = 1'b1;
            if (alu_entry_valid[i] && alu_entry_rd[i*ADDR_W +: ADDR_W] == mem_rd)
                mem_rd_in_alu = 1'b1;
        end
    end

    // MEM wins a same-cycle collision on one register; mem_ready never looks
    // at ALU inputs, so the ALU ready path cannot loop back on itself.
    assign mem_ready = !mem_full && !(mem_rd_in_alu && mem_rd != '0);
    assign alu_ready = !alu_full
                    && !(alu_rd != '0 && (alu_rd_in_mem
                                          || (mem_valid && mem_ready && mem_rd == alu_rd)));
    assign alu_push  = alu_valid && alu_ready;
    assign mem_push  = mem_valid && mem_ready;

    // Round-robin: pref_q names the source to favour on the next tie and is
    // flipped to the other source after every grant.
    always_comb begin
        any_pending = !alu_empty || !mem_empty;
        if (!alu_empty && !mem_empty) grant = pref_q;
        else if (!mem_empty)          grant = SRC_MEM;
        else                          grant = SRC_ALU;

        alu_pop     = any_pending && (grant == SRC_ALU);
        mem_pop     = any_pending && (grant == SRC_MEM);

        pref_d      = pref_q;
        reg_write_d = 1'b0;
        wreg_d      = wreg_q;
        wdata_d     = wdata_q;
        if (any_pending) begin
            pref_d      = ~grant;
            wreg_d      = (grant == SRC_ALU) ? alu_head_rd   : mem_head_rd;
            wdata_d     = (grant == SRC_ALU) ? alu_head_data : mem_head_data;
            // rd 0 entries drain through the stage without a write strobe.
            reg_write_d = (wreg_d != '0);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pref_q      <= SRC_MEM;
            reg_write_q <= 1'b0;
            wreg_q      <= '0;
            wdata_q     <= '0;
        end else begin
            pref_q      <= pref_d;
            reg_write_q <= reg_write_d;
            wreg_q      <= wreg_d;
            wdata_q     <= wdata_d;
        end
    end

    assign RegWrite      = reg_write_q;
    assign WriteRegister = wreg_q;
    assign WriteData     = wdata_q;

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (alu_entry_valid[i]) busy_mask[alu_entry_rd[i*ADDR_W +: ADDR_W]] = 1'b1;
            if (mem_entry_valid[i]) busy_mask[mem_entry_rd[i*ADDR_W +: ADDR_W]] = 1'b1;
        end
        if (reg_write_q) busy_mask[wreg_q] = 1'b1;
        busy_mask[0] = 1'b0;
    end

`ifdef WB_FWD_EN
    always_comb begin
        fwd_hit1  = reg_write_q && (wreg_q == fwd_rs1) && (fwd_rs1 != '0);
        fwd_hit2  = reg_write_q && (wreg_q == fwd_rs2) && (fwd_rs2 != '0);
        fwd_data1 = fwd_hit1 ? wdata_q : '0;
        fwd_data2 = fwd_hit2 ? wdata_q : '0;
    end
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// tb_writeback_arbiter
// Directed bench for writeback_arbiter (default build, FIFO_DEPTH = 2):
// a vector table for single-write latency, WAW stall, rd 0 and MEM-side stall,
// then hand-written sequences for round-robin/full-FIFO and mid-run reset.
// -----------------------------------------------------------------------------
module tb_writeback_arbiter;
    import writeback_pkg::*;

    logic                clock = 1'b0;
    logic                reset_n;
    logic                alu_valid, alu_ready, mem_valid, mem_ready;
    logic [3:0]          alu_rd, mem_rd;
    logic [31:0]         alu_data, mem_data;
    logic                RegWrite;
    logic [3:0]          WriteRegister;
    logic [31:0]         WriteData;
    logic [NUM_REGS-1:0] busy_mask;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    writeback_arbiter #(.DATA_W(32), .ADDR_W(4), .FIFO_DEPTH(2)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_rd        (mem_rd),
        .mem_data      (mem_data),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .busy_mask     (busy_mask)
    );

    typedef struct {
        logic        av;
        logic [3:0]  ard;
        logic [31:0] adat;
        logic        mv;
        logic [3:0]  mrd;
        logic [31:0] mdat;
        logic        e_ar;
        logic        e_mr;
        logic        e_rw;
        logic [3:0]  e_wr;
        logic [31:0] e_wd;
        logic [15:0] e_busy;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(input logic av, input logic [3:0] ard, input logic [31:0] adat,
                                input logic mv, input logic [3:0] mrd, input logic [31:0] mdat,
                                input logic e_ar, input logic e_mr, input logic e_rw,
                                input logic [3:0] e_wr, input logic [31:0] e_wd,
                                input logic [15:0] e_busy);
        vec_t v;
        v.av = av;     v.ard = ard;   v.adat = adat;
        v.mv = mv;     v.mrd = mrd;   v.mdat = mdat;
        v.e_ar = e_ar; v.e_mr = e_mr; v.e_rw = e_rw;
        v.e_wr = e_wr; v.e_wd = e_wd; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [3:0] ard, input logic [31:0] adat,
                         input logic mv, input logic [3:0] mrd, input logic [31:0] mdat);
        alu_valid = av; alu_rd = ard; alu_data = adat;
        mem_valid = mv; mem_rd = mrd; mem_data = mdat;
    endtask

    // Leaves the bench 1 time unit after a rising edge with reset released.
    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    logic [3:0]  rr_exp[8];
    logic        alu_rdy_exp[5];
    logic        mem_rdy_exp[5];
    logic [3:0]  got_rd[$];
    logic [31:0] got_data[$];

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;

        // ---------------- reset values ----------------
        #2;
        check("reset RegWrite",      32'(RegWrite),      32'd0);
        check("reset WriteRegister", 32'(WriteRegister), 32'd0);
        check("reset WriteData",     WriteData,          32'd0);
        check("reset busy_mask",     32'(busy_mask),     32'd0);

        // ---------------- vector table ----------------
        //               av ard adat          mv mrd mdat      ar mr rw wr  wd            busy
        vecs[0]  = mk(0, 0, 0,             0, 0, 0,         1, 1, 0, 0, 0,            16'h0000);
        vecs[1]  = mk(1, 3, 32'hDEADBEEF,  0, 0, 0,         1, 1, 0, 0, 0,            16'h0000);
        vecs[2]  = mk(0, 0, 0,             0, 0, 0,         1, 1, 0, 0, 0,            16'h0008);
        vecs[3]  = mk(0, 0, 0,             0, 0, 0,         1, 1, 1, 3, 32'hDEADBEEF, 16'h0008);
        vecs[4]  = mk(0, 0, 0,             0, 0, 0,         1, 1, 0, 0, 0,            16'h0000);
        vecs[5]  = mk(1, 7, 32'hA1,        1, 7, 32'hB2,    0, 1, 0, 0, 0,            16'h0000);
        vecs[6]  = mk(1, 7, 32'hA1,        0, 0, 0,         0, 1, 0, 0, 0,            16'h0080);
        vecs[7]  = mk(1, 7, 32'hA1,        0, 0, 0,         1, 1, 1, 7, 32'hB2,       16'h0080);
        vecs[8]  = mk(0, 0, 0,             0, 0, 0,         1, 1, 0, 0, 0,            16'h0080);
        vecs[9]  = mk(0, 0, 0,             0, 0, 0,         1, 1, 1, 7, 32'hA1,       16'h0080);
        vecs[10] = mk(0, 0, 0,             0, 0, 0,         1, 1, 0, 0, 0,            16'h0000);
        vecs[11] = mk(1, 0, 32'h55,        0, 0, 0,         1, 1, 0, 0, 0,            16'h0000);
        vecs[12] = mk(0, 0, 0,             0, 0, 0,         1, 1, 0, 0, 0,            16'h0000);
        vecs[13] = mk(0, 0, 0,             0, 0, 0,         1, 1, 0, 0, 0,            16'h0000);
        vecs[14] = mk(1, 0, 32'h11,        1, 0, 32'h22,    1, 1, 0, 0, 0,            16'h0000);
        vecs[15] = mk(0, 0, 0,             0, 0, 0,         1, 1, 0, 0, 0,            16'h0000);
        vecs[16] = mk(0, 0, 0,             0, 0, 0,         1, 1, 0, 0, 0,            16'h0000);
        vecs[17] = mk(0, 0, 0,             0, 0, 0,         1, 1, 0, 0, 0,            16'h0000);
        vecs[18] = mk(1, 9, 32'h99,        0, 0, 0,         1, 1, 0, 0, 0,            16'h0000);
        vecs[19] = mk(0, 0, 0,             1, 9, 32'h77,    1, 0, 0, 0, 0,            16'h0200);
        vecs[20] = mk(0, 0, 0,             1, 9, 32'h77,    1, 1, 1, 9, 32'h99,       16'h0200);
        vecs[21] = mk(0, 0, 0,             0, 0, 0,         1, 1, 0, 0, 0,            16'h0200);
        vecs[22] = mk(0, 0, 0,             0, 0, 0,         1, 1, 1, 9, 32'h77,       16'h0200);
        vecs[23] = mk(0, 0, 0,             0, 0, 0,         1, 1, 0, 0, 0,            16'h0000);

        @(posedge clock);
        @(posedge clock);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].av, vecs[i].ard, vecs[i].adat, vecs[i].mv, vecs[i].mrd, vecs[i].mdat);
            #2;
            check($sformatf("v%0d alu_ready", i), 32'(alu_ready), 32'(vecs[i].e_ar));
            check($sformatf("v%0d mem_ready", i), 32'(mem_ready), 32'(vecs[i].e_mr));
            check($sformatf("v%0d RegWrite", i),  32'(RegWrite),  32'(vecs[i].e_rw));
            check($sformatf("v%0d busy_mask", i), 32'(busy_mask), 32'(vecs[i].e_busy));
            if (vecs[i].e_rw) begin
                check($sformatf("v%0d WriteRegister", i), 32'(WriteRegister), 32'(vecs[i].e_wr));
                check($sformatf("v%0d WriteData", i),     WriteData,          vecs[i].e_wd);
            end
            @(posedge clock);
            #1;
        end

        // ------------- round-robin, full ALU FIFO, pointer wrap -------------
        // MEM offers rd 1..4, ALU rd 5..8, both always valid until drained.
        rr_exp = '{4'd1, 4'd5, 4'd2, 4'd6, 4'd3, 4'd7, 4'd4, 4'd8};
        alu_rdy_exp = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        mem_rdy_exp = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        do_reset();
        begin
            int mi = 0;
            int ai = 0;
            int first_cyc = -1;
            int last_cyc  = -1;
            logic take_a, take_m;
            for (int cyc = 0; cyc < 30; cyc++) begin
                drive(ai < 4, 4'(ai + 5), 32'h2000 + 32'(ai + 5),
                      mi < 4, 4'(mi + 1), 32'h1000 + 32'(mi + 1));
                #2;
                if (cyc < 5) begin
                    check($sformatf("rr c%0d alu_ready", cyc), 32'(alu_ready), 32'(alu_rdy_exp[cyc]));
                    check($sformatf("rr c%0d mem_ready", cyc), 32'(mem_ready), 32'(mem_rdy_exp[cyc]));
                end
                take_a = alu_valid && alu_ready;
                take_m = mem_valid && mem_ready;
                if (RegWrite) begin
                    got_rd.push_back(WriteRegister);
                    got_data.push_back(WriteData);
                    if (first_cyc < 0) first_cyc = cyc;
                    last_cyc = cyc;
                end
                @(posedge clock);
                #1;
                if (take_a) ai++;
                if (take_m) mi++;
            end
            drive(0, 0, 0, 0, 0, 0);
            check("rr write count", 32'(got_rd.size()), 32'd8);
            for (int k = 0; k < 8; k++) begin
                if (k < got_rd.size()) begin
                    check($sformatf("rr order %0d", k), 32'(got_rd[k]), 32'(rr_exp[k]));
                    check($sformatf("rr data %0d", k), got_data[k],
                          (rr_exp[k] < 4'd5 ? 32'h1000 : 32'h2000) + 32'(rr_exp[k]));
                end
            end
            check("rr back-to-back span", 32'(last_cyc - first_cyc), 32'd7);
        end

        // ---------------- reset in the middle of traffic ----------------
        do_reset();
        drive(1, 5, 32'h2005, 1, 1, 32'h1001);
        @(posedge clock);
        #1 drive(1, 6, 32'h2006, 1, 2, 32'h1002);
        @(posedge clock);
        #1 drive(0, 0, 0, 0, 0, 0);
        #1;
        // Output holds rd1; MEM queue holds rd2; ALU queue holds rd5, rd6.
        check("mid pre-reset RegWrite",  32'(RegWrite),      32'd1);
        check("mid pre-reset WriteReg",  32'(WriteRegister), 32'd1);
        check("mid pre-reset busy_mask", 32'(busy_mask),     32'h0066);
        reset_n = 1'b0;
        #1;
        check("mid reset RegWrite",      32'(RegWrite),      32'd0);
        check("mid reset WriteRegister", 32'(WriteRegister), 32'd0);
        check("mid reset WriteData",     WriteData,          32'd0);
        check("mid reset busy_mask",     32'(busy_mask),     32'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #2;
            check($sformatf("post-reset c%0d RegWrite", c),  32'(RegWrite),  32'd0);
            check($sformatf("post-reset c%0d busy_mask", c), 32'(busy_mask), 32'd0);
            check($sformatf("post-reset c%0d alu_ready", c), 32'(alu_ready), 32'd1);
            @(posedge clock);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
